// File: rtl/ysyx_mem_arbiter.sv
// rtl/ysyx_mem_arbiter.sv - IFU/LSU arbiter onto a single AXI4-Lite-style master port
module ysyx_mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 15,
    parameter int CNT_W      = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] ifu_araddr,
    input  logic            ifu_arvalid,
    output logic [XLEN-1:0] ifu_rdata,
    output logic            ifu_rvalid,
    input  logic [XLEN-1:0] lsu_araddr,
    input  logic            lsu_arvalid,
    input  logic [7:0]      lsu_rstrb,
    output logic [XLEN-1:0] lsu_rdata,
    output logic            lsu_rvalid,
    input  logic [XLEN-1:0] lsu_awaddr,
    input  logic            lsu_awvalid,
    input  logic [XLEN-1:0] lsu_wdata,
    input  logic [7:0]      lsu_wstrb,
    output logic            lsu_wready,
    output logic [XLEN-1:0] bus_araddr,
    output logic [2:0]      bus_arsize,
    output logic            bus_arvalid,
    input  logic            bus_arready,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic [1:0]      bus_rresp,
    input  logic            bus_rvalid,
    output logic            bus_rready,
    output logic [XLEN-1:0] bus_awaddr,
    output logic            bus_awvalid,
    input  logic            bus_awready,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    output logic            bus_wvalid,
    input  logic            bus_wready,
    input  logic [1:0]      bus_bresp,
    input  logic            bus_bvalid,
    output logic            bus_bready,
    output logic            out_err,
    output logic [XLEN-1:0] out_err_addr
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B} state_t;

    state_t           state, state_nxt;
    logic             own_ifu;
    logic [XLEN-1:0]  addr_q, wdata_q;
    logic [2:0]       size_q;
    logic [3:0]       wstrb_q;
    logic             aw_done, w_done;
    logic [CNT_W-1:0] starve;
    logic             grant_ifu, grant_st, grant_ld;
    logic             ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [2:0]       lsu_size;
    logic             unused_wstrb_hi;

    assign unused_wstrb_hi = ^lsu_wstrb[7:4];

    always_comb begin
        grant_ifu = 1'b0;
        grant_st  = 1'b0;
        grant_ld  = 1'b0;
        if (state == IDLE) begin
            if (starve == CNT_W'(STARVE_MAX) && ifu_arvalid) grant_ifu = 1'b1;
            else if (lsu_awvalid)                             grant_st  = 1'b1;
            else if (lsu_arvalid)                             grant_ld  = 1'b1;
            else if (ifu_arvalid)                             grant_ifu = 1'b1;
        end
    end

    always_comb begin
        case (lsu_rstrb)
            8'h01:   lsu_size = 3'd0;
            8'h03:   lsu_size = 3'd1;
            default: lsu_size = 3'd2;
        endcase
    end

    assign bus_arvalid = (state == RD_A);
    assign bus_rready  = (state == RD_D);
    assign bus_awvalid = (state == WR_A) && !aw_done;
    assign bus_wvalid  = (state == WR_A) && !w_done;
    assign bus_bready  = (state == WR_B);
    assign bus_araddr  = addr_q;
    assign bus_awaddr  = addr_q;
    assign bus_arsize  = size_q;
    assign bus_wdata   = wdata_q;
    assign bus_wstrb   = wstrb_q;

    assign ar_hs = bus_arvalid && bus_arready;
    assign r_hs  = bus_rready  && bus_rvalid;
    assign aw_hs = bus_awvalid && bus_awready;
    assign w_hs  = bus_wvalid  && bus_wready;
    assign b_hs  = bus_bready  && bus_bvalid;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_st) state_nxt = WR_A;
                     else if (grant_ld || grant_ifu) state_nxt = RD_A;
            RD_A:    if (ar_hs) state_nxt = RD_D;
            RD_D:    if (r_hs) state_nxt = IDLE;
            // AW and W may complete in either order; B waits for both
            WR_A:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_B;
            WR_B:    if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            own_ifu      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= 3'd0;
            wstrb_q      <= 4'd0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            starve       <= '0;
            ifu_rdata    <= '0;
            lsu_rdata    <= '0;
            ifu_rvalid   <= 1'b0;
            lsu_rvalid   <= 1'b0;
            lsu_wready   <= 1'b0;
            out_err      <= 1'b0;
            out_err_addr <= '0;
        end else begin
            state <= state_nxt;
            // a requester that let go of its valid gets no completion pulse
            ifu_rvalid <= r_hs && own_ifu && ifu_arvalid;
            lsu_rvalid <= r_hs && !own_ifu && lsu_arvalid;
            lsu_wready <= b_hs && lsu_awvalid;
            if (grant_ifu || grant_ld || grant_st) begin
                own_ifu <= grant_ifu;
                addr_q  <= grant_ifu ? ifu_araddr : (grant_st ? lsu_awaddr : lsu_araddr);
                size_q  <= grant_ld ? lsu_size : 3'd2;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (grant_st) begin
                wdata_q <= lsu_wdata;
                wstrb_q <= lsu_wstrb[3:0];
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
            if (grant_ifu)
                starve <= '0;
            else if (state == IDLE && ifu_arvalid && starve != CNT_W'(STARVE_MAX))
                starve <= starve + 1'b1;
            if (r_hs) begin
                if (own_ifu) ifu_rdata <= bus_rdata;
                else         lsu_rdata <= bus_rdata;
            end
            if (!out_err && ((r_hs && bus_rresp != 2'd0) || (b_hs && bus_bresp != 2'd0))) begin
                out_err      <= 1'b1;
                out_err_addr <= addr_q;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb/tb_ysyx_mem_arbiter.sv - directed and randomized checks of ysyx_mem_arbiter against a transaction model
module tb_ysyx_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ifu_araddr, ifu_rdata, lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
    logic        ifu_arvalid, ifu_rvalid, lsu_arvalid, lsu_rvalid, lsu_awvalid, lsu_wready;
    logic [7:0]  lsu_rstrb, lsu_wstrb;
    logic [31:0] bus_araddr, bus_rdata, bus_awaddr, bus_wdata, out_err_addr;
    logic [2:0]  bus_arsize;
    logic        bus_arvalid, bus_arready, bus_rvalid, bus_rready;
    logic        bus_awvalid, bus_awready, bus_wvalid, bus_wready, bus_bvalid, bus_bready;
    logic [1:0]  bus_rresp, bus_bresp;
    logic [3:0]  bus_wstrb;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ysyx_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready),
        .bus_araddr(bus_araddr), .bus_arsize(bus_arsize), .bus_arvalid(bus_arvalid), .bus_arready(bus_arready),
        .bus_rdata(bus_rdata), .bus_rresp(bus_rresp), .bus_rvalid(bus_rvalid), .bus_rready(bus_rready),
        .bus_awaddr(bus_awaddr), .bus_awvalid(bus_awvalid), .bus_awready(bus_awready),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid), .bus_wready(bus_wready),
        .bus_bresp(bus_bresp), .bus_bvalid(bus_bvalid), .bus_bready(bus_bready),
        .out_err(out_err), .out_err_addr(out_err_addr)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction, fixed priority plus IFU starvation rescue
    logic        m_busy, m_rd, m_own_ifu, m_ar_done, m_aw_done, m_w_done;
    logic [31:0] m_addr, m_wdata, m_ifu_data, m_lsu_data, m_err_addr;
    logic [2:0]  m_size;
    logic [3:0]  m_wstrb;
    logic        m_err, m_ifu_pulse, m_lsu_pulse, m_wr_pulse;
    int          m_starve, m_who;

    function automatic logic [2:0] size_of(input logic [7:0] strb);
        if (strb == 8'h01) return 3'd0;
        if (strb == 8'h03) return 3'd1;
        return 3'd2;
    endfunction

    task automatic note_err(input logic [1:0] resp);
        if (resp != 2'd0 && !m_err) begin
            m_err      = 1'b1;
            m_err_addr = m_addr;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_busy = 0; m_rd = 0; m_own_ifu = 0; m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
            m_addr = 0; m_wdata = 0; m_ifu_data = 0; m_lsu_data = 0; m_size = 0; m_wstrb = 0;
            m_err = 0; m_err_addr = 0; m_ifu_pulse = 0; m_lsu_pulse = 0; m_wr_pulse = 0; m_starve = 0;
            return;
        end
        m_ifu_pulse = 0; m_lsu_pulse = 0; m_wr_pulse = 0;
        if (!m_busy) begin
            if (m_starve == 15 && ifu_arvalid) m_who = 1;
            else if (lsu_awvalid)              m_who = 2;
            else if (lsu_arvalid)              m_who = 3;
            else if (ifu_arvalid)              m_who = 1;
            else                               m_who = 0;
            if (m_who == 1) m_starve = 0;
            else if (ifu_arvalid && m_starve < 15) m_starve = m_starve + 1;
            if (m_who != 0) begin
                m_busy = 1; m_rd = (m_who != 2); m_own_ifu = (m_who == 1);
                m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
                m_addr = (m_who == 1) ? ifu_araddr : (m_who == 2) ? lsu_awaddr : lsu_araddr;
                m_size = (m_who == 3) ? size_of(lsu_rstrb) : 3'd2;
                if (m_who == 2) begin
                    m_wdata = lsu_wdata;
                    m_wstrb = lsu_wstrb[3:0];
                end
            end
        end else if (m_rd) begin
            if (!m_ar_done) begin
                if (bus_arready) m_ar_done = 1;
            end else if (bus_rvalid) begin
                if (m_own_ifu) begin m_ifu_data = bus_rdata; m_ifu_pulse = ifu_arvalid; end
                else           begin m_lsu_data = bus_rdata; m_lsu_pulse = lsu_arvalid; end
                note_err(bus_rresp);
                m_busy = 0;
            end
        end else begin
            if (m_aw_done && m_w_done) begin
                if (bus_bvalid) begin
                    m_wr_pulse = lsu_awvalid;
                    note_err(bus_bresp);
                    m_busy = 0;
                end
            end else begin
                if (bus_awready) m_aw_done = 1;
                if (bus_wready)  m_w_done  = 1;
            end
        end
    endtask

    task automatic compare();
        chk1("arvalid", bus_arvalid, m_busy && m_rd && !m_ar_done);
        chk1("rready",  bus_rready,  m_busy && m_rd && m_ar_done);
        chk1("awvalid", bus_awvalid, m_busy && !m_rd && !m_aw_done);
        chk1("wvalid",  bus_wvalid,  m_busy && !m_rd && !m_w_done);
        chk1("bready",  bus_bready,  m_busy && !m_rd && m_aw_done && m_w_done);
        chk1("ifu_rvalid", ifu_rvalid, m_ifu_pulse);
        chk1("lsu_rvalid", lsu_rvalid, m_lsu_pulse);
        chk1("lsu_wready", lsu_wready, m_wr_pulse);
        chk1("out_err", out_err, m_err);
        chk32("out_err_addr", out_err_addr, m_err_addr);
        if (m_busy && m_rd && !m_ar_done) begin
            chk32("araddr", bus_araddr, m_addr);
            chk32("arsize", 32'(bus_arsize), 32'(m_size));
        end
        if (m_busy && !m_rd && !m_aw_done) chk32("awaddr", bus_awaddr, m_addr);
        if (m_busy && !m_rd && !m_w_done) begin
            chk32("wdata", bus_wdata, m_wdata);
            chk32("wstrb", 32'(bus_wstrb), 32'(m_wstrb));
        end
        if (m_ifu_pulse) chk32("ifu_rdata", ifu_rdata, m_ifu_data);
        if (m_lsu_pulse) chk32("lsu_rdata", lsu_rdata, m_lsu_data);
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clock);
        compare();
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic slave(input logic arr, input logic rv, input logic [31:0] rd, input logic [1:0] rr,
                         input logic awr, input logic wr, input logic bv);
        bus_arready = arr; bus_rvalid = rv; bus_rdata = rd; bus_rresp = rr;
        bus_awready = awr; bus_wready = wr; bus_bvalid = bv; bus_bresp = 2'd0;
    endtask

    int n, cnt, got;

    initial begin
        reset = 1'b1;
        ifu_araddr = 0; ifu_arvalid = 0; lsu_araddr = 0; lsu_arvalid = 0; lsu_rstrb = 0;
        lsu_awaddr = 0; lsu_awvalid = 0; lsu_wdata = 0; lsu_wstrb = 0;
        slave(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk1("rst_arvalid", bus_arvalid, 1'b0);
        chk1("rst_awvalid", bus_awvalid, 1'b0);
        chk32("rst_araddr", bus_araddr, 32'h0);
        chk1("rst_err", out_err, 1'b0);
        reset = 1'b0;

        // zero-wait IFU fetch
        slave(1, 1, 32'h0000_0413, 0, 0, 0, 0);
        tick();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000;
        tick();
        chk1("t1_arvalid_n1", bus_arvalid, 1'b1);
        chk32("t1_araddr", bus_araddr, 32'h8000_0000);
        chk32("t1_arsize", 32'(bus_arsize), 32'd2);
        tick();
        chk1("t1_rready_n2", bus_rready, 1'b1);
        chk1("t1_no_pulse_n2", ifu_rvalid, 1'b0);
        tick();
        chk1("t1_pulse_n3", ifu_rvalid, 1'b1);
        chk32("t1_rdata", ifu_rdata, 32'h0000_0413);
        ifu_arvalid = 0;
        tick();
        chk1("t1_pulse_once", ifu_rvalid, 1'b0);

        // store and load in the same cycle
        slave(1, 1, 32'h1234_5678, 0, 1, 1, 1);
        lsu_awvalid = 1; lsu_awaddr = 32'h8000_1000; lsu_wdata = 32'hdead_beef; lsu_wstrb = 8'h03;
        lsu_arvalid = 1; lsu_araddr = 32'h8000_2000; lsu_rstrb = 8'h0f;
        tick();
        chk1("t2_awvalid", bus_awvalid, 1'b1);
        chk32("t2_wstrb", 32'(bus_wstrb), 32'h3);
        chk32("t2_wdata", bus_wdata, 32'hdead_beef);
        chk1("t2_load_waits", bus_arvalid, 1'b0);
        n = 0;
        while (!lsu_wready && n < 20) begin tick(); n++; end
        chk1("t2_wready_pulse", lsu_wready, 1'b1);
        lsu_awvalid = 0;
        tick();
        chk1("t2_load_next", bus_arvalid, 1'b1);
        chk32("t2_load_addr", bus_araddr, 32'h8000_2000);
        n = 0;
        while (!lsu_rvalid && n < 20) begin tick(); n++; end
        chk32("t2_load_data", lsu_rdata, 32'h1234_5678);
        lsu_arvalid = 0;

        // back-to-back loads against a waiting IFU
        slave(1, 1, 32'h0bad_f00d, 0, 0, 0, 0);
        tick();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0100;
        lsu_arvalid = 1; lsu_araddr = 32'h2000_0000; lsu_rstrb = 8'h0f;
        cnt = 0; got = 0; n = 0;
        while (!got && n < 400) begin
            tick(); n++;
            if (lsu_rvalid) cnt++;
            if (bus_arvalid && bus_araddr == 32'h8000_0100) got = 1;
        end
        chk1("t3_ifu_granted", got[0], 1'b1);
        chk32("t3_loads_before_ifu", cnt, 32'd15);
        n = 0;
        while (!ifu_rvalid && n < 20) begin tick(); n++; end
        chk1("t3_ifu_done", ifu_rvalid, 1'b1);
        tick();
        chk32("t3_lsu_wins_after_clear", bus_araddr, 32'h2000_0000);
        ifu_arvalid = 0;
        n = 0;
        while (!lsu_rvalid && n < 20) begin tick(); n++; end
        lsu_arvalid = 0;

        // AW accepted three cycles before W
        slave(0, 0, 0, 0, 1, 0, 1);
        tick();
        lsu_awvalid = 1; lsu_awaddr = 32'h8000_3000; lsu_wdata = 32'hcafe_f00d; lsu_wstrb = 8'h0f;
        tick();
        chk1("t4_aw_n1", bus_awvalid, 1'b1);
        chk1("t4_w_n1", bus_wvalid, 1'b1);
        tick();
        chk1("t4_aw_dropped", bus_awvalid, 1'b0);
        chk1("t4_w_held", bus_wvalid, 1'b1);
        tick();
        chk1("t4_w_held2", bus_wvalid, 1'b1);
        tick();
        bus_wready = 1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (lsu_wready) begin cnt++; lsu_awvalid = 0; end
        end
        chk32("t4_one_pulse", cnt, 32'd1);

        // error responses: first address sticks
        slave(1, 1, 32'h0000_0055, 2, 0, 0, 0);
        lsu_arvalid = 1; lsu_araddr = 32'h1000_0000; lsu_rstrb = 8'h01;
        n = 0;
        while (!lsu_rvalid && n < 20) begin tick(); n++; end
        chk1("t5_pulse", lsu_rvalid, 1'b1);
        chk32("t5_rdata", lsu_rdata, 32'h0000_0055);
        chk1("t5_err", out_err, 1'b1);
        chk32("t5_err_addr", out_err_addr, 32'h1000_0000);
        lsu_araddr = 32'h2000_0004; bus_rresp = 2'd3;
        tick();
        n = 0;
        while (!lsu_rvalid && n < 20) begin tick(); n++; end
        chk1("t5_pulse2", lsu_rvalid, 1'b1);
        chk32("t5_err_addr_kept", out_err_addr, 32'h1000_0000);
        lsu_arvalid = 0; bus_rresp = 2'd0;

        // reset while waiting for R data
        slave(1, 0, 32'h7777_7777, 0, 0, 0, 0);
        tick();
        lsu_arvalid = 1; lsu_araddr = 32'h3000_0000;
        n = 0;
        while (!bus_rready && n < 20) begin tick(); n++; end
        chk1("t6_in_rd_d", bus_rready, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("t6_async_rready", bus_rready, 1'b0);
        chk1("t6_async_err", out_err, 1'b0);
        chk32("t6_async_err_addr", out_err_addr, 32'h0);
        lsu_arvalid = 0; bus_rvalid = 1;
        tick(); tick();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (lsu_rvalid) cnt++;
        end
        chk32("t6_no_pulse", cnt, 32'd0);
        slave(1, 1, 32'h0000_0413, 0, 0, 0, 0);
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000;
        n = 0;
        while (!ifu_rvalid && n < 20) begin tick(); n++; end
        chk1("t6_clean_fetch", ifu_rvalid, 1'b1);
        chk32("t6_clean_data", ifu_rdata, 32'h0000_0413);
        ifu_arvalid = 0;

        // randomized traffic with occasional abandoned requests and error responses
        for (int c = 0; c < 4000; c++) begin
            tick();
            bus_arready = 1'($urandom_range(0, 1));
            bus_rvalid  = 1'($urandom_range(0, 1));
            bus_awready = 1'($urandom_range(0, 1));
            bus_wready  = 1'($urandom_range(0, 1));
            bus_bvalid  = 1'($urandom_range(0, 1));
            bus_rdata   = $urandom;
            bus_rresp   = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bus_bresp   = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if (ifu_rvalid || (ifu_arvalid && $urandom_range(0, 63) == 0)) ifu_arvalid = 0;
            if (!ifu_arvalid && $urandom_range(0, 2) == 0) begin
                ifu_arvalid = 1; ifu_araddr = $urandom;
            end
            if (lsu_rvalid || (lsu_arvalid && $urandom_range(0, 63) == 0)) lsu_arvalid = 0;
            if (!lsu_arvalid && $urandom_range(0, 3) == 0) begin
                lsu_arvalid = 1; lsu_araddr = $urandom;
                case ($urandom_range(0, 2))
                    0:       lsu_rstrb = 8'h01;
                    1:       lsu_rstrb = 8'h03;
                    default: lsu_rstrb = 8'h0f;
                endcase
            end
            if (lsu_wready || (lsu_awvalid && $urandom_range(0, 63) == 0)) lsu_awvalid = 0;
            if (!lsu_awvalid && $urandom_range(0, 5) == 0) begin
                lsu_awvalid = 1; lsu_awaddr = $urandom; lsu_wdata = $urandom; lsu_wstrb = 8'($urandom);
            end
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_mem_arbiter.md
Name: ysyx_mem_arbiter

Overview:
Arbitrates the single backend memory bus between the IFU instruction-fetch port and the LSU load/store port. Presents an AXI4-Lite-style master (separate AR/R/AW/W/B channels, one outstanding transaction) and returns single-cycle completion pulses to each requester. Sits between the core's IFU/LSU and the SoC crossbar. Priority is fixed: LSU store > LSU load > IFU, with an anti-starvation counter that guarantees IFU forward progress.

Parameters:
XLEN, 32, address/data width
STARVE_MAX, 15, consecutive IFU-wait cycles after which IFU wins the next grant
CNT_W, 4, width of starvation counter (must hold STARVE_MAX)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ifu_araddr  in  XLEN  fetch address
ifu_arvalid  in  1  fetch request, held until ifu_rvalid
ifu_rdata  out  XLEN  fetch data, valid with ifu_rvalid
ifu_rvalid  out  1  one-cycle fetch-complete pulse
lsu_araddr  in  XLEN  load address
lsu_arvalid  in  1  load request, held until lsu_rvalid
lsu_rstrb  in  8  load byte strobe, forwarded on bus_arsize
lsu_rdata  out  XLEN  load data, valid with lsu_rvalid
lsu_rvalid  out  1  one-cycle load-complete pulse
lsu_awaddr  in  XLEN  store address
lsu_awvalid  in  1  store request, held until lsu_wready
lsu_wdata  in  XLEN  store data
lsu_wstrb  in  8  store byte strobe (low 4 bits used)
lsu_wready  out  1  one-cycle store-complete pulse
bus_araddr  out  XLEN  AR address
bus_arsize  out  3  0/1/2 for rstrb 0x1/0x3/0xf; 2 for IFU
bus_arvalid  out  1  AR valid
bus_arready  in  1  AR ready
bus_rdata  in  XLEN  R data
bus_rresp  in  2  R response
bus_rvalid  in  1  R valid
bus_rready  out  1  R ready
bus_awaddr  out  XLEN  AW address
bus_awvalid  out  1  AW valid
bus_awready  in  1  AW ready
bus_wdata  out  XLEN  W data
bus_wstrb  out  4  W strobe
bus_wvalid  out  1  W valid
bus_wready  in  1  W ready
bus_bresp  in  2  B response
bus_bvalid  in  1  B valid
bus_bready  out  1  B ready
out_err  out  1  sticky bus-error flag
out_err_addr  out  XLEN  address of first erroring transaction

Behaviour:
- Reset (async assert): state IDLE; all valid/ready/pulse outputs 0; bus_* data/address and rdata outputs 0; starve counter 0; out_err 0; out_err_addr 0.
- States: IDLE, RD_A, RD_D, WR_A, WR_B.
- IDLE grant (cycle N, combinational on inputs): if starve==STARVE_MAX and ifu_arvalid -> IFU read; else lsu_awvalid -> store; else lsu_arvalid -> LSU read; else ifu_arvalid -> IFU read. On grant, owner, address, size, wdata, wstrb are latched; next state RD_A or WR_A. Bus valid asserts in cycle N+1 (registered).
- RD_A: bus_arvalid=1 until bus_arready; -> RD_D. RD_D: bus_rready=1; on bus_rvalid capture data into owner's rdata register, pulse owner's rvalid next cycle, -> IDLE.
- WR_A: bus_awvalid and bus_wvalid both asserted; each drops independently after its own handshake; when both are done (same or different cycles) -> WR_B. WR_B: bus_bready=1; on bus_bvalid pulse lsu_wready next cycle, -> IDLE.
- Minimum read latency with zero-wait slave: grant N, AR handshake N+1, R N+2, rvalid pulse N+3. A new grant is possible in the pulse cycle.
- Starvation counter: increments (saturating at STARVE_MAX) each IDLE cycle where ifu_arvalid=1 and IFU is not granted; holds outside IDLE; clears on IFU grant.
- Requester drops valid mid-transaction: bus transaction still completes; completion pulse is suppressed.
- Simultaneous store and load: store wins; load waits. A new request arriving during a busy state is held by the requester; no queuing.
- rresp/bresp != 0: completion still pulses (rdata passed through); if out_err=0, set out_err=1 and latch the transaction address. Sticky until reset.
- Reset mid-transaction: immediate return to IDLE; outstanding bus transaction is abandoned; no pulses.

Test Plan:
- IFU fetch 0x80000000 alone, zero-wait slave with rdata 0x00000413 -> bus_arvalid at N+1, ifu_rvalid pulse at N+3 with ifu_rdata=0x00000413, bus_arsize=2.
- Same-cycle lsu_awvalid (addr 0x80001000, wdata 0xdeadbeef, wstrb 0x3) and lsu_arvalid -> store issued first (bus_wstrb=0x3), lsu_wready pulse, then load granted.
- IFU held valid while LSU issues back-to-back loads -> IFU granted on the grant after 15 waiting IDLE cycles, and starve resets to 0.
- AW ready 3 cycles before W ready -> awvalid drops after its handshake, wvalid holds, exactly one lsu_wready pulse.
- Load at 0x10000000 returning rresp=2 -> lsu_rvalid pulses, out_err=1, out_err_addr=0x10000000; a second error leaves the address unchanged.
- Reset asserted in RD_D -> outputs 0 asynchronously, no rvalid pulse, next grant starts cleanly.
